// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers, one byte per grant.
// Optional watchdog on the TX_Done wait is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLOCKS_PER_BIT = 217,
    parameter int unsigned TIMEOUT_CYCLES = (DATA_WIDTH + 4) * CLOCKS_PER_BIT
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    output logic [NUM_REQ-1:0]                         req_ready,
    output logic [NUM_REQ-1:0]                         req_done,
    output logic                                       tx_data_valid,
    output logic [DATA_WIDTH-1:0]                      tx_byte,
    input  logic                                       tx_active,
    input  logic                                       tx_done,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                       busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                                       timeout_err
`endif
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DW_ALL = NUM_REQ * DATA_WIDTH;

    localparam logic [1:0] ARB_IDLE      = 2'd0;
    localparam logic [1:0] ARB_LAUNCH    = 2'd1;
    localparam logic [1:0] ARB_WAIT_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_id_d;
    logic [GW-1:0]         sel_c;
    logic [GW-1:0]         next_ptr_c;
    logic                  found_c;
    logic [DATA_WIDTH-1:0] sel_data_c;
    logic [DATA_WIDTH-1:0] tx_byte_d;
    logic [NUM_REQ-1:0]    req_ready_d, req_done_d;
    logic                  tx_data_valid_d;
    logic                  busy_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_err_d;
`endif

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic [NUM_REQ-1:0] shifted;
        logic [DW_ALL-1:0]  data_sh;
        int unsigned        idx;
        sel_c   = '0;
        found_c = 1'b0;
        shifted = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            shifted = req_valid >> idx;
            if (!found_c && shifted[0]) begin
                found_c = 1'b1;
                sel_c   = GW'(idx);
            end
        end
        data_sh    = req_data >> (32'(sel_c) * DATA_WIDTH);
        sel_data_c = data_sh[DATA_WIDTH-1:0];
    end

    assign next_ptr_c = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id;
        tx_byte_d       = tx_byte;
        req_ready_d     = '0;
        req_done_d      = '0;
        tx_data_valid_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d        = '0;
        timeout_err_d   = timeout_err;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (found_c && !tx_active) begin
                    state_d     = ARB_LAUNCH;
                    tx_byte_d   = sel_data_c;
                    grant_id_d  = sel_c;
                    req_ready_d = NUM_REQ'(1) << sel_c;
                end
            end
            ARB_LAUNCH: begin
                tx_data_valid_d = 1'b1;
                state_d         = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                if (tx_done) begin
                    req_done_d = NUM_REQ'(1) << grant_id;
                    rr_ptr_d   = next_ptr_c;
                    state_d    = ARB_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Give up on a silent UART; the grant is dropped without req_done.
                else if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = next_ptr_c;
                    state_d       = ARB_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            grant_id      <= '0;
            tx_byte       <= '0;
            req_ready     <= '0;
            req_done      <= '0;
            tx_data_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id      <= grant_id_d;
            tx_byte       <= tx_byte_d;
            req_ready     <= req_ready_d;
            req_done      <= req_done_d;
            tx_data_valid <= tx_data_valid_d;
            busy          <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-level round-robin model and a mock UART.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done;
    logic            tx_data_valid;
    logic [DW-1:0]   tx_byte;
    logic            tx_active;
    logic            tx_done;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    uart_tx_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .tx_data_valid (tx_data_valid),
        .tx_byte       (tx_byte),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    bit            pend[N];
    logic [DW-1:0] pdata[N];
    logic [N-1:0]  xtra;
    int            rr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend[i] | xtra[i];
            req_data[i*DW +: DW] = pdata[i];
        end
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    // One full grant/launch/done cycle; called at a negedge with requests already driven.
    task automatic run_txn(input int uart_len, input int wd_req, input int hold_active, output int w);
        int            waited;
        logic [DW-1:0] exp_byte;
        w = pick_winner();
        if (w < 0) return;
        if (hold_active > 0) begin
            tx_active = 1'b1;
            for (int k = 0; k < hold_active; k++) begin
                @(negedge clk);
                check_eq("busy_uart_no_ready", 32'(req_ready), 0);
            end
            tx_active = 1'b0;
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (req_ready == '0 && waited < 8);
        check_eq("grant_latency", waited, 1);
        check_eq("req_ready", 32'(req_ready), 32'(1) << w);
        check_eq("grant_id", 32'(grant_id), w);
        exp_byte = pdata[w];
        pend[w]  = 1'b0;
        drive_req();
        @(negedge clk);
        check_eq("tx_data_valid", 32'(tx_data_valid), 1);
        check_eq("tx_byte", 32'(tx_byte), 32'(exp_byte));
        tx_active = 1'b1;
        for (int k = 0; k < uart_len; k++) begin
            @(negedge clk);
            check_eq("busy_window", {29'd0, busy, tx_data_valid, |req_ready}, 32'h4);
            check_eq("early_done", 32'(req_done), 0);
            if (wd_req >= 0 && k == 0) xtra[wd_req] = 1'b1;
            if (wd_req >= 0 && k == 1) xtra[wd_req] = 1'b0;
            drive_req();
        end
        xtra      = '0;
        drive_req();
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("req_done", 32'(req_done), 32'(1) << w);
        check_eq("tx_byte_hold", 32'(tx_byte), 32'(exp_byte));
        check_eq("busy_clear", 32'(busy), 0);
        rr = (w + 1) % N;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {req_ready, req_done, tx_data_valid, tx_byte, grant_id, busy}, 0);
    endtask

    initial begin
        int w;
        int wd;
        int cands[$];
        rst_n     = 1'b0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        xtra      = '0;
        rr        = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        drive_req();
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting continuously: strict rotation.
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b1;
            pdata[i] = DW'($urandom);
        end
        drive_req();
        for (int t = 0; t < 5; t++) begin
            run_txn(10, -1, 0, w);
            pend[w]  = 1'b1;
            pdata[w] = DW'($urandom);
            drive_req();
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_req();
        @(negedge clk);

        // Single request from requester 2.
        pend[2]  = 1'b1;
        pdata[2] = 8'hA5;
        drive_req();
        run_txn(30, -1, 0, w);

        // Requester 1 withdraws during requester 0's transfer; 2 is next.
        pend[0]  = 1'b1;
        pdata[0] = 8'h11;
        pend[2]  = 1'b1;
        pdata[2] = 8'h22;
        drive_req();
        run_txn(8, 1, 0, w);
        run_txn(8, -1, 0, w);

        // UART busy while idle holds the grant off.
        pend[0]  = 1'b1;
        pdata[0] = 8'h5A;
        drive_req();
        run_txn(6, -1, 4, w);

        // Asynchronous reset in the middle of a transfer.
        pend[1]  = 1'b1;
        pdata[1] = 8'h3C;
        drive_req();
        @(negedge clk);
        check_eq("pre_reset_ready", 32'(req_ready), 32'h2);
        pend[1] = 1'b0;
        drive_req();
        @(negedge clk);
        tx_active = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        tx_active = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("no_done_after_reset", {30'd0, |req_done, busy}, 0);
            @(negedge clk);
        end
        rr = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b1;
            pdata[i] = DW'($urandom);
        end
        drive_req();
        run_txn(5, -1, 0, w);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = DW'($urandom);
                end
            end
            if (pick_winner() < 0) begin
                wd        = int'($urandom_range(0, N - 1));
                pend[wd]  = 1'b1;
                pdata[wd] = DW'($urandom);
            end
            drive_req();
            cands.delete();
            for (int i = 0; i < N; i++) if (!pend[i]) cands.push_back(i);
            wd = (cands.size() > 0 && $urandom_range(0, 2) == 0)
                 ? cands[$urandom_range(0, cands.size() - 1)] : -1;
            run_txn(int'($urandom_range(2, 25)), wd,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0, w);
        end

`ifdef UART_ARB_TIMEOUT_EN
        begin
            bit done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
            check_eq("timeout_err_clear", 32'(timeout_err), 0);
            pend[1]  = 1'b1;
            pdata[1] = 8'h77;
            drive_req();
            @(negedge clk);
            check_eq("to_ready", 32'(req_ready), 32'h2);
            pend[1] = 1'b0;
            drive_req();
            @(negedge clk);
            check_eq("to_launch", 32'(tx_data_valid), 1);
            tx_active = 1'b1;
            for (int k = 1; k <= 2604; k++) begin
                @(negedge clk);
                done_seen = done_seen | (|req_done);
                if (k == 2603) check_eq("timeout_not_yet", 32'(timeout_err), 0);
            end
            check_eq("timeout_set", 32'(timeout_err), 1);
            check_eq("timeout_idle", 32'(busy), 0);
            check_eq("timeout_no_done", 32'(done_seen), 0);
            tx_active = 1'b0;
            rr        = 2;
            pend[0]   = 1'b1;
            pdata[0]  = 8'h01;
            pend[3]   = 1'b1;
            pdata[3]  = 8'h03;
            drive_req();
            run_txn(5, -1, 0, w);
            check_eq("timeout_sticky", 32'(timeout_err), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
